// File: rtl/fp_credit_fifo.sv
// fp_credit_fifo: receiving end of the fixed-latency FP result path.
// A credit counter throttles operation issue so that every result leaving the
// non-stallable FP pipeline finds room in a small result FIFO; the FIFO head is
// presented to the consumer as a ready/valid stream.
// Optional feature macro: FP_CREDIT_FIFO_BYPASS_EN (zero-latency empty bypass).
module fp_credit_fifo #(
  parameter int unsigned EXP   = 8,
  parameter int unsigned MANT  = 9,
  parameter int unsigned WIDTH = 1 + EXP + MANT,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             clock_sreset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             result_valid,
  input  logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow,
  output logic [CW-1:0]    credits
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_credits;
  logic             r_overflow;
  logic [WIDTH-1:0] r_hold;

  logic             w_empty;
  logic             w_full;
  logic             w_pop_fifo;
  logic             w_bypass;
  logic             w_byp_take;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_out_data;
  logic             w_pop;
  logic             w_issue;
  logic             w_wr;
  logic             w_drop;

  // Pointers wrap at DEPTH-1 so any DEPTH works, not only powers of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop_fifo = ~w_empty & out_ready;

`ifdef FP_CREDIT_FIFO_BYPASS_EN
  // Empty FIFO: an arriving result is shown to the consumer in the same cycle.
  assign w_bypass   = w_empty & result_valid;
  assign w_byp_take = w_bypass & out_ready;
`else
  assign w_bypass   = 1'b0;
  assign w_byp_take = 1'b0;
`endif

  // Head presentation; when nothing is available the last head is held.
  always_comb begin
    w_out_valid = ~w_empty | w_bypass;
    w_out_data  = r_hold;
    if (!w_empty) begin
      w_out_data = r_mem[r_rd_ptr];
    end else if (w_bypass) begin
      w_out_data = result;
    end
  end

  assign w_pop   = w_out_valid & out_ready;
  assign w_issue = issue_valid & issue_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_wr    = result_valid & ~w_byp_take & (~w_full | w_pop_fifo);
  assign w_drop  = result_valid & w_full & ~w_pop_fifo;

  assign issue_ready = (r_credits != '0);
  assign out_valid   = w_out_valid;
  assign out_data    = w_out_data;
  assign overflow    = r_overflow;
  assign credits     = r_credits;

  // Result storage; contents are qualified by pointers and count, so no reset.
  always_ff @(posedge clock) begin
    if (w_wr && !clock_sreset) begin
      r_mem[r_wr_ptr] <= result;
    end
  end

  // Pointers, occupancy, held head value and sticky overflow.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_hold     <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop_fifo) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      if (w_pop) begin
        r_hold <= w_out_data;
      end
      case ({w_wr, w_pop_fifo})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Credit counter: issue takes a credit, every consumed word returns one.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_credits <= CW'(DEPTH);
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   if (r_credits != CW'(DEPTH)) r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_credit_fifo.sv
// Bench for fp_credit_fifo: a queue-based model plus a 2-cycle pipeline model
// drive and predict every output each cycle; literal checks pin key points.
module tb_fp_credit_fifo;

  localparam int W     = 18;
  localparam int DEPTH = 4;
`ifdef FP_CREDIT_FIFO_BYPASS_EN
  localparam bit BYP_ON = 1'b1;
`else
  localparam bit BYP_ON = 1'b0;
`endif

  logic         clock;
  logic         clock_sreset;
  logic         issue_valid;
  logic         issue_ready;
  logic         result_valid;
  logic [W-1:0] result;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         overflow;
  logic [2:0]   credits;

  fp_credit_fifo dut (
    .clock        (clock),
    .clock_sreset (clock_sreset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .result_valid (result_valid),
    .result       (result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .overflow     (overflow),
    .credits      (credits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state
  logic [W-1:0] m_q[$];
  int           m_credits;
  logic         m_over;
  logic [W-1:0] m_last;
  // Pipeline model (LCYCLES = 2)
  logic         p_v [2];
  logic [W-1:0] p_d [2];
  logic [W-1:0] next_data;

  int   n_checks;
  int   n_err;
  logic chk_en;
  logic         s_ov;
  logic [W-1:0] s_od;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare at negedge, advance model at posedge.
  task automatic cyc(input logic iv, input logic ordy, input logic frv,
                     input logic [W-1:0] fdat, input logic rst);
    int           sz;
    logic         byp, e_ov, pop, iss;
    logic [W-1:0] e_od;
    issue_valid  = iv;
    out_ready    = ordy;
    clock_sreset = rst;
    result_valid = p_v[1] | frv;
    result       = frv ? fdat : p_d[1];
    @(negedge clock);
    sz   = m_q.size();
    byp  = BYP_ON && (sz == 0) && result_valid;
    e_ov = (sz != 0) || byp;
    e_od = (sz != 0) ? m_q[0] : (byp ? result : m_last);
    s_ov = out_valid;
    s_od = out_data;
    if (chk_en) begin
      chk("issue_ready", 32'(issue_ready), 32'(m_credits != 0));
      chk("credits",     32'(credits),     32'(m_credits));
      chk("out_valid",   32'(out_valid),   32'(e_ov));
      chk("out_data",    32'(out_data),    32'(e_od));
      chk("overflow",    32'(overflow),    32'(m_over));
    end
    @(posedge clock);
    iss = iv && (m_credits != 0) && !rst;
    pop = e_ov && ordy;
    if (rst) begin
      m_q.delete();
      m_credits = DEPTH;
      m_over    = 1'b0;
      m_last    = '0;
      p_v[0] = 1'b0; p_v[1] = 1'b0;
    end else begin
      if (pop) m_last = e_od;
      if (pop && sz != 0) void'(m_q.pop_front());
      if (result_valid) begin
        if (byp && ordy) begin
          // consumed straight from the pipeline
        end else if (sz < DEPTH || pop) begin
          m_q.push_back(result);
        end else begin
          m_over = 1'b1;
        end
      end
      m_credits = m_credits - int'(iss) + int'(pop);
      if (m_credits > DEPTH) m_credits = DEPTH;
      if (m_credits < 0) m_credits = 0;
      p_v[1] = p_v[0];
      p_d[1] = p_d[0];
      p_v[0] = iss;
      p_d[0] = next_data;
      if (iss) next_data = next_data + W'(1);
    end
    #1;
  endtask

  initial begin
    n_checks = 0; n_err = 0; chk_en = 1'b0;
    m_credits = DEPTH; m_over = 1'b0; m_last = '0;
    p_v[0] = 1'b0; p_v[1] = 1'b0; p_d[0] = '0; p_d[1] = '0;
    next_data = W'(18'h00100);
    clock_sreset = 1'b1; issue_valid = 1'b0; out_ready = 1'b0;
    result_valid = 1'b0; result = '0;

    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);
    chk_en = 1'b1;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_credits",     32'(credits),     32'd4);
    chk("rst_out_valid",   32'(out_valid),   32'd0);
    chk("rst_out_data",    32'(out_data),    32'd0);
    chk("rst_overflow",    32'(overflow),    32'd0);

    // Fill: issue every cycle, consumer stalled.
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, '0, 0);
    chk("fill_credits",     32'(credits),     32'd0);
    chk("fill_issue_ready", 32'(issue_ready), 32'd0);
    chk("fill_out_valid",   32'(out_valid),   32'd1);
    chk("fill_out_data",    32'(out_data),    32'h00100);
    chk("fill_overflow",    32'(overflow),    32'd0);

    // Write and pop with a full FIFO: head leaves, new word joins the tail.
    cyc(0, 1, 1, W'(18'h0AAAA), 0);
    chk("wrpop_out_data", 32'(out_data), 32'h00101);
    // Arrival into a full FIFO with no pop: dropped, sticky overflow.
    cyc(0, 0, 1, W'(18'h1FFFF), 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    cyc(0, 0, 0, '0, 0);
    chk("ovf_held", 32'(overflow), 32'd1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, '0, 0);
    chk("drain_last", 32'(out_data), 32'h0AAAA);

    // Reset mid-stream with three words stored and one in flight.
    cyc(0, 0, 0, '0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 1);
    chk("mid_rst_credits",   32'(credits),   32'd4);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data",  32'(out_data),  32'd0);
    chk("mid_rst_overflow",  32'(overflow),  32'd0);

    // Steady state: issue and consume every cycle.
    next_data = W'(18'h02000);
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, '0, 0);
    chk("steady_credits", 32'(credits), BYP_ON ? 32'd2 : 32'd1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, '0, 0);
    chk("idle_credits", 32'(credits), 32'd4);

    // Simultaneous issue and pop with two credits left.
    cyc(1, 0, 0, '0, 0);
    cyc(1, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);
    cyc(1, 1, 0, '0, 0);
    chk("iss_pop_credits", 32'(credits), 32'd2);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, '0, 0);

    // Result latency from an empty FIFO.
    next_data = W'(18'h1ABCD);
    cyc(1, 1, 0, '0, 0);
    cyc(0, 1, 0, '0, 0);
    cyc(0, 1, 0, '0, 0);
`ifdef FP_CREDIT_FIFO_BYPASS_EN
    chk("byp_same_valid", 32'(s_ov), 32'd1);
    chk("byp_same_data",  32'(s_od), 32'h1ABCD);
    chk("byp_after_valid", 32'(out_valid), 32'd0);
    chk("byp_credits",     32'(credits),   32'd4);
`else
    chk("lat_same_valid", 32'(s_ov), 32'd0);
    chk("lat_next_valid", 32'(out_valid), 32'd1);
    chk("lat_next_data",  32'(out_data),  32'h1ABCD);
    chk("lat_credits",    32'(credits),   32'd3);
`endif
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0, 0);
    chk("end_credits", 32'(credits), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fp_credit_fifo.md
# fp_credit_fifo

Receiving end of the fixed-latency FP result path. FP arithmetic and latency pipelines take no backpressure, so results that leave them must always be accepted. This block owns a small result FIFO and issues credits to the operation issuer, so no issued operation ever finds the FIFO full on arrival. It converts the pipeline's fire-and-forget `result_valid`/`result` stream into a ready/valid stream for downstream consumers.

## Interface
Parameters:
- `EXP`, 8, exponent width
- `MANT`, 9, mantissa width
- `WIDTH`, 1+EXP+MANT, word width
- `DEPTH`, 4, FIFO entries; ≥1, any integer; must be ≥ pipeline LCYCLES+1 for full throughput
- `CW`, $clog2(DEPTH+1), credit/count width

Ports:
- `clock`  in  1  sole clock
- `clock_sreset`  in  1  reset, synchronous, active-high
- `issue_valid`  in  1  upstream issues one op into the FP pipeline this cycle
- `issue_ready`  out  1  a credit is available; issue permitted
- `result_valid`  in  1  pipeline result arriving
- `result`  in  WIDTH  pipeline result data
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  consumer accepts head
- `out_data`  out  WIDTH  head entry
- `overflow`  out  1  sticky: result arrived with no space (protocol violation)
- `credits`  out  CW  current free credits (debug/observe)

## Operation
- Credit counter `credits`: reset to DEPTH. Decrement on issue (`issue_valid & issue_ready`); increment on pop (`out_valid & out_ready`). Both in one cycle → unchanged. Never exceeds DEPTH, never below 0.
- `issue_ready = (credits != 0)`, combinational from the register. `issue_valid` while `issue_ready=0` is ignored and does not change credits.
- Storage: flop array of DEPTH words, write pointer, read pointer, occupancy `count`. Pointers wrap from DEPTH-1 to 0 (not power-of-two masking).
- Write on `result_valid` when `count<DEPTH`, or when `count==DEPTH` and a pop occurs the same cycle.
- Arrival with `count==DEPTH` and no pop → result dropped, `overflow` set and held until reset. Credits are not adjusted.
- `out_valid = (count != 0)`. `out_data = mem[rd_ptr]` when valid, else the last head value.
- Pop on `out_valid & out_ready`: advance the read pointer.
- Write and pop in the same cycle → `count` unchanged.
- Invariant while the protocol is obeyed: `credits + count + in_flight == DEPTH`.
- Reset mid-operation: all state returns to reset values. The upstream pipeline shares `clock_sreset`, so in-flight results vanish with it. Any `result_valid` in the reset cycle is ignored.

## Timing
- Reset values: `issue_ready=1` (DEPTH≥1), `credits=DEPTH`, `out_valid=0`, `out_data=0`, `overflow=0`.
- Issue→credit: `issue_ready` reflects a decrement the cycle after the issue edge.
- Result→output: a word written at edge N gives `out_valid=1` in cycle N+1 (default build).
- Pop→credit: a credit returned at edge N allows a new issue in cycle N+1.
- Throughput: one result per cycle sustained when DEPTH ≥ LCYCLES+1 and `out_ready` is held high.

## Configuration
- `FP_CREDIT_FIFO_BYPASS_EN` defined:
  - When `count==0` and `result_valid=1`, then `out_valid=1` and `out_data=result` in the same cycle.
  - If `out_ready=1`, the word is consumed without a write, and the credit is returned that edge.
  - Otherwise it is written normally.
  - Result→output latency is 0 cycles when empty.
- Not defined: no combinational path from `result`/`result_valid` to the outputs; latency is 1 cycle as above.

## Test plan
- Reset → `issue_ready=1`, `credits=4`, `out_valid=0`, `overflow=0`. Assert reset mid-stream with count=3 → all reset values the next cycle.
- DEPTH=4, LCYCLES=2 model, `out_ready=0`, issue every cycle:
  - Exactly 4 issues accepted; `issue_ready=0` from cycle 4.
  - `count` reaches 4; `out_data` = first result.
  - `overflow=0`.
- Same setup, then `out_ready=1`:
  - Results pop in issue order.
  - One credit per pop; issues resume the cycle after each pop.
  - Steady state: 1 op/cycle, `credits` constant.
- Force `result_valid` with `count=4`, `out_ready=0` → word dropped, `overflow=1` held, FIFO contents unchanged.
- Simultaneous issue and pop with `credits=2` → `credits` stays 2. Write and pop with `count=4` → `count` stays 4; the new word is at the tail.
- Bypass, empty FIFO, `result=0x1ABCD`, `out_ready=1` → `out_valid=1` and `out_data=0x1ABCD` in the same cycle, `count` stays 0. Without the macro → `out_valid` rises the next cycle.
